// File: rtl/i2c_master_engine.sv
// rtl/i2c_master_engine.sv - I2C write engine: START, three bytes with ACK checks, STOP
// Outputs are registered from next-state values so they line up with the current quarter phase.
module i2c_master_engine #(
  parameter int unsigned CLK_DIV = 125
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start_trans,
  input  logic [23:0] trans_data,
  input  logic        sda_in,
  output logic        scl_oe,
  output logic        sda_oe,
  output logic        idle,
  output logic        cl_high,
  output logic        ack_err
);

  localparam logic [7:0] LAST = 8'(CLK_DIV - 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_BIT, S_ACK, S_STOP} state_t;

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [1:0]  q_q, q_d;
  logic [23:0] shreg_q, shreg_d;
  logic [2:0]  bit_q, bit_d;
  logic [1:0]  byte_q, byte_d;
  logic        pend_q, pend_d;
  logic        ack_err_q, ack_err_d;
  logic        scl_q, scl_d;
  logic        sda_q, sda_d;
  logic        idle_q, idle_d;
  logic        cl_q, cl_d;
  logic        tick, wrap;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= 8'd0;
      q_q       <= 2'd0;
      shreg_q   <= 24'd0;
      bit_q     <= 3'd0;
      byte_q    <= 2'd0;
      pend_q    <= 1'b0;
      ack_err_q <= 1'b0;
      scl_q     <= 1'b0;
      sda_q     <= 1'b0;
      idle_q    <= 1'b1;
      cl_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      q_q       <= q_d;
      shreg_q   <= shreg_d;
      bit_q     <= bit_d;
      byte_q    <= byte_d;
      pend_q    <= pend_d;
      ack_err_q <= ack_err_d;
      scl_q     <= scl_d;
      sda_q     <= sda_d;
      idle_q    <= idle_d;
      cl_q      <= cl_d;
    end
  end

  always_comb begin
    tick      = (cnt_q == LAST);
    wrap      = tick && (q_q == 2'd3);
    cnt_d     = tick ? 8'd0 : cnt_q + 8'd1;
    q_d       = tick ? q_q + 2'd1 : q_q;
    state_d   = state_q;
    shreg_d   = shreg_q;
    bit_d     = bit_q;
    byte_d    = byte_q;
    pend_d    = pend_q;
    ack_err_d = ack_err_q;

    case (state_q)
      // An accepted request waits in pend until the period boundary.
      S_IDLE: begin
        if (start_trans && idle_q) begin
          shreg_d   = trans_data;
          ack_err_d = 1'b0;
          pend_d    = 1'b1;
        end
        if (wrap && pend_q) begin
          state_d = S_START;
          pend_d  = 1'b0;
        end
      end
      S_START: begin
        if (wrap) begin
          state_d = S_BIT;
          bit_d   = 3'd0;
          byte_d  = 2'd0;
        end
      end
      S_BIT: begin
        if (wrap) begin
          shreg_d = {shreg_q[22:0], 1'b0};
          if (bit_q == 3'd7) begin
            bit_d   = 3'd0;
            state_d = S_ACK;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end
      end
      S_ACK: begin
        if (tick && (q_q == 2'd2) && sda_in) ack_err_d = 1'b1;
        if (wrap) begin
          if (ack_err_q || (byte_q == 2'd2)) begin
            state_d = S_STOP;
          end else begin
            byte_d  = byte_q + 2'd1;
            bit_d   = 3'd0;
            state_d = S_BIT;
          end
        end
      end
      S_STOP: begin
        if (wrap) begin
          state_d = S_IDLE;
          bit_d   = 3'd0;
          byte_d  = 2'd0;
        end
      end
      default: state_d = S_IDLE;
    endcase

    scl_d = 1'b0;
    sda_d = 1'b0;
    case (state_d)
      S_START: sda_d = q_d[1];
      S_BIT: begin
        scl_d = ~q_d[1];
        sda_d = ~shreg_d[23];
      end
      S_ACK:   scl_d = ~q_d[1];
      S_STOP: begin
        scl_d = (q_d == 2'd0);
        sda_d = ~q_d[1];
      end
      default: ;
    endcase
    idle_d = (state_d == S_IDLE) && !pend_d;
    cl_d   = tick && (q_q == 2'd2);
  end

  assign scl_oe  = scl_q;
  assign sda_oe  = sda_q;
  assign idle    = idle_q;
  assign cl_high = cl_q;
  assign ack_err = ack_err_q;

endmodule
